// File: rtl/spi_adc_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_adc_responder_if
//  Description : SPI link between the FPGA master and the emulated ADC.
//                The master drives sclk/mosi/ncs. The responder drives miso
//                and miso_oe, where miso_oe models the tri-state enable.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_adc_responder_if;
    logic sclk;
    logic mosi;
    logic ncs;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output mosi, output ncs, input miso, input miso_oe);
    modport slave  (input sclk, input mosi, input ncs, output miso, output miso_oe);
endinterface
`default_nettype wire

// File: rtl/spi_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_adc_responder
//  Description : Emulates an MCP3002-style 10-bit ADC on the SPI link. It
//                decodes the start, SGL, ODD and MSBF bits. It then returns
//                the selected sample, or the clamped pseudo-differential
//                sample, MSB-first, with an optional LSB-first tail.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_adc_responder #(
    parameter int DATA_W      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    spi_adc_responder_if.slave  spi,
    input  logic [DATA_W-1:0]   ch0,
    input  logic [DATA_W-1:0]   ch1,
    output logic                busy,
    output logic                done,
    output logic [2:0]          last_cfg
);

    localparam int c_CNT_W = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        CFG   = 3'd2,
        NULLB = 3'd3,
        MSB   = 3'd4,
        LSB   = 3'd5,
        DONE  = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_rise;
    logic                   r_fall;
    logic                   r_mosi_smp;

    state_t                 r_state, w_state_nxt;
    logic                   r_miso, w_miso_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [2:0]             r_cfg, w_cfg_nxt;
    logic [DATA_W-1:0]      r_conv, w_conv_nxt;
    logic                   r_done, w_done_nxt;
    logic [2:0]             r_last_cfg, w_last_cfg_nxt;

    logic                   w_ncs;
    logic                   w_fall;
    logic [DATA_W:0]        w_diff;
    logic [DATA_W-1:0]      w_conv;

    // Synchronize the SPI pins and register the detected sclk edges with the aligned mosi sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_ncs_sync  <= '1;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_mosi_smp  <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], spi.ncs};
            r_rise      <=  r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
            r_fall      <= ~r_sclk_sync[SYNC_STAGES-2] &  r_sclk_sync[SYNC_STAGES-1];
            r_mosi_smp  <= r_mosi_sync[SYNC_STAGES-1];
        end
    end

    assign w_ncs  = r_ncs_sync[SYNC_STAGES-1];
    // A falling edge seen together with a rising edge is treated as a glitch.
    assign w_fall = r_fall & ~r_rise;

    // Build the conversion word from the decoded channel selection; differences clamp at zero.
    always_comb begin
        w_diff = r_cfg[1] ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
        if (r_cfg[2]) begin
            w_conv = r_cfg[1] ? ch1 : ch0;
        end else if (w_diff[DATA_W]) begin
            w_conv = '0;
        end else begin
            w_conv = w_diff[DATA_W-1:0];
        end
    end

    // Register the frame state, the shift data and the status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_miso     <= 1'b0;
            r_cnt      <= '0;
            r_cfg      <= '0;
            r_conv     <= '0;
            r_done     <= 1'b0;
            r_last_cfg <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_miso     <= w_miso_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cfg      <= w_cfg_nxt;
            r_conv     <= w_conv_nxt;
            r_done     <= w_done_nxt;
            r_last_cfg <= w_last_cfg_nxt;
        end
    end

    // Decode the frame: collect the header on rising edges and shift the data out on falling edges.
    always_comb begin
        w_state_nxt    = r_state;
        w_miso_nxt     = r_miso;
        w_cnt_nxt      = r_cnt;
        w_cfg_nxt      = r_cfg;
        w_conv_nxt     = r_conv;
        w_done_nxt     = 1'b0;
        w_last_cfg_nxt = r_last_cfg;

        if (w_ncs) begin
            // Deselect discards the partial frame.
            w_state_nxt = IDLE;
            w_miso_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = START;
                    w_miso_nxt  = 1'b0;
                end
                START: begin
                    if (r_rise && r_mosi_smp) begin
                        w_state_nxt = CFG;
                        w_cnt_nxt   = '0;
                    end
                end
                CFG: begin
                    if (r_rise) begin
                        w_cfg_nxt = {r_cfg[1:0], r_mosi_smp};
                        if (r_cnt == c_CNT_W'(2)) begin
                            w_state_nxt = NULLB;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                NULLB: begin
                    if (w_fall) begin
                        w_conv_nxt  = w_conv;
                        w_miso_nxt  = 1'b0;
                        w_cnt_nxt   = c_CNT_W'(DATA_W - 1);
                        w_state_nxt = MSB;
                    end
                end
                MSB: begin
                    if (w_fall) begin
                        w_miso_nxt = r_conv[r_cnt];
                        if (r_cnt == '0) begin
                            if (r_cfg[0]) begin
                                w_state_nxt    = DONE;
                                w_done_nxt     = 1'b1;
                                w_last_cfg_nxt = r_cfg;
                            end else begin
                                w_state_nxt = LSB;
                                w_cnt_nxt   = c_CNT_W'(1);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - 1'b1;
                        end
                    end
                end
                LSB: begin
                    if (w_fall) begin
                        w_miso_nxt = r_conv[r_cnt];
                        if (r_cnt == c_CNT_W'(DATA_W - 1)) begin
                            w_state_nxt    = DONE;
                            w_done_nxt     = 1'b1;
                            w_last_cfg_nxt = r_cfg;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (w_fall) begin
                        w_miso_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_miso_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign spi.miso_oe = (r_state != IDLE);
    assign spi.miso    = r_miso;
    assign done        = r_done;
    assign last_cfg    = r_last_cfg;

endmodule
`default_nettype wire

// File: tb/tb_spi_adc_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_adc_responder
//  Description : Directed bench for spi_adc_responder. A bench-side SPI master
//                clocks complete frames. The received miso stream is compared
//                with the bit stream predicted from the selected channel
//                arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_adc_responder;

    localparam int DATA_W      = 10;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] ch0 = '0;
    logic [DATA_W-1:0] ch1 = '0;
    logic              busy;
    logic              done;
    logic [2:0]        last_cfg;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    logic [2:0] exp_cfg    = 3'b000;
    logic [2:0] model_last = 3'b000;

    spi_adc_responder_if spi ();

    spi_adc_responder #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .spi      (spi),
        .ch0      (ch0),
        .ch1      (ch1),
        .busy     (busy),
        .done     (done),
        .last_cfg (last_cfg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The ADC transfer function, taken directly from the channel rules.
    function automatic logic [DATA_W-1:0] model_word(input bit sgl, input bit odd,
                                                      input logic [DATA_W-1:0] a,
                                                      input logic [DATA_W-1:0] b);
        int d;
        if (sgl) return odd ? b : a;
        d = odd ? (int'(b) - int'(a)) : (int'(a) - int'(b));
        return (d < 0) ? '0 : d[DATA_W-1:0];
    endfunction

    // Per-cycle check of status outputs against the model.
    always @(negedge clk) begin
        if (reset) begin
            check("oe_tracks_busy", spi.miso_oe, busy);
            if (!busy) begin
                check("idle_miso", spi.miso, 1'b0);
                check("idle_done", done, 1'b0);
                check("idle_last_cfg", last_cfg, model_last);
            end
            if (done) begin
                done_cnt++;
                check("done_last_cfg", last_cfg, exp_cfg);
            end
        end
    end

    // One master frame: optional leading zeros, a header, then sampling before each rising edge.
    task automatic run_frame(input string tag, input int lead, input bit sgl, input bit odd,
                             input bit msbf, input int abort_after, input logic [DATA_W-1:0] lit_word,
                             input bit late_en, input logic [DATA_W-1:0] ch0_late);
        logic [DATA_W-1:0] word;
        logic [DATA_W-1:0] got;
        logic              exp_q[$];
        logic              hdr[$];
        int                d0;
        word = model_word(sgl, odd, ch0, ch1);
        check({tag, "_model"}, word, lit_word);
        exp_q.push_back(1'b0);
        for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(word[b]);
        if (!msbf) for (int b = 1; b < DATA_W; b++) exp_q.push_back(word[b]);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int i = 0; i < lead; i++) hdr.push_back(1'b0);
        hdr.push_back(1'b1);
        hdr.push_back(sgl);
        hdr.push_back(odd);
        hdr.push_back(msbf);
        exp_cfg = {sgl, odd, msbf};
        d0  = done_cnt;
        got = '0;

        spi.ncs = 1'b0;
        wait_clks(HALF);
        foreach (hdr[i]) begin
            spi.mosi = hdr[i];
            wait_clks(HALF);
            check($sformatf("%s_hdr_miso%0d", tag, i), spi.miso, 1'b0);
            check($sformatf("%s_hdr_oe%0d", tag, i), spi.miso_oe, 1'b1);
            spi.sclk = 1'b1;
            wait_clks(HALF);
            spi.sclk = 1'b0;
        end
        spi.mosi = 1'b0;

        for (int i = 0; i < exp_q.size(); i++) begin
            wait_clks(HALF);
            check($sformatf("%s_bit%0d", tag, i), spi.miso, exp_q[i]);
            if (i >= 1 && i <= DATA_W) got = {got[DATA_W-2:0], spi.miso};
            if (i == 0 && late_en) ch0 = ch0_late;
            if (i == abort_after) break;
            if (i < exp_q.size() - 1) begin
                spi.sclk = 1'b1;
                wait_clks(HALF);
                spi.sclk = 1'b0;
            end
        end

        if (abort_after >= 0) begin
            spi.ncs = 1'b1;
            wait_clks(SYNC_STAGES + 1);
            check({tag, "_abort_oe"}, spi.miso_oe, 1'b0);
            check({tag, "_abort_busy"}, busy, 1'b0);
            check({tag, "_abort_miso"}, spi.miso, 1'b0);
            check({tag, "_abort_no_done"}, done_cnt - d0, 0);
            check({tag, "_abort_last_cfg"}, last_cfg, model_last);
        end else begin
            check({tag, "_word"}, got, lit_word);
            check({tag, "_done_once"}, done_cnt - d0, 1);
            model_last = exp_cfg;
            spi.ncs = 1'b1;
            wait_clks(SYNC_STAGES + 3);
            check({tag, "_end_busy"}, busy, 1'b0);
            check({tag, "_last_cfg"}, last_cfg, {sgl, odd, msbf});
        end
        wait_clks(HALF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.ncs  = 1'b1;
        reset    = 1'b0;
        wait_clks(3);
        check("rst_miso", spi.miso, 1'b0);
        check("rst_oe", spi.miso_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_last_cfg", last_cfg, 3'b000);
        reset = 1'b1;
        wait_clks(4);

        ch0 = 10'h2A5; ch1 = 10'h000;
        run_frame("sgl_ch0_msbf", 0, 1'b1, 1'b0, 1'b1, -1, 10'h2A5, 1'b0, '0);
        ch1 = 10'h301;
        run_frame("sgl_ch1_lsbf", 0, 1'b1, 1'b1, 1'b0, -1, 10'h301, 1'b0, '0);
        ch0 = 10'd100; ch1 = 10'd300;
        run_frame("diff_clamp", 0, 1'b0, 1'b0, 1'b1, -1, 10'd0, 1'b0, '0);
        run_frame("diff_pos", 0, 1'b0, 1'b1, 1'b1, -1, 10'h0C8, 1'b0, '0);
        ch0 = 10'h3FF;
        run_frame("lead0", 0, 1'b1, 1'b0, 1'b1, -1, 10'h3FF, 1'b0, '0);
        run_frame("lead2", 2, 1'b1, 1'b0, 1'b1, -1, 10'h3FF, 1'b0, '0);
        run_frame("abort", 0, 1'b1, 1'b1, 1'b0, 4, 10'h12C, 1'b0, '0);
        run_frame("after_abort", 0, 1'b1, 1'b0, 1'b1, -1, 10'h3FF, 1'b0, '0);
        ch0 = 10'h155;
        run_frame("late_ch0", 0, 1'b1, 1'b0, 1'b1, -1, 10'h155, 1'b1, 10'h2AA);

        // Reset in the middle of a frame returns everything to reset values immediately.
        spi.ncs = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 6; i++) begin
            spi.mosi = (i < 4) ? 1'b1 : 1'b0;
            wait_clks(HALF);
            spi.sclk = 1'b1;
            wait_clks(HALF);
            spi.sclk = 1'b0;
        end
        wait_clks(HALF);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_oe", spi.miso_oe, 1'b0);
        check("midrst_miso", spi.miso, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_last_cfg", last_cfg, 3'b000);
        model_last = 3'b000;
        spi.ncs  = 1'b1;
        spi.mosi = 1'b0;
        wait_clks(3);
        reset = 1'b1;
        wait_clks(4);
        run_frame("post_reset", 0, 1'b1, 1'b0, 1'b0, -1, 10'h2AA, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
